// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-transfer initiator with response channel and bus timeout
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [DW-1:0] cmd_dat_i,
    input  logic [3:0]    cmd_sel_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_dat_o,
    output logic          rsp_err_o,
    output logic          rsp_tmo_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          start;
    logic          finish;
    logic          fin_err;
    logic          fin_tmo;
    logic [DW-1:0] fin_dat;
    logic          rsp_pop;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_o = 1'b0;
        start       = 1'b0;
        finish      = 1'b0;
        fin_err     = 1'b0;
        fin_tmo     = 1'b0;
        fin_dat     = '0;
        rsp_pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // state_q already reads IDLE during reset, so gate ready explicitly
                cmd_ready_o = wb_rst_ni;
                if (cmd_valid_i) begin
                    start   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_err_i) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else if (wb_ack_i) begin
                    finish  = 1'b1;
                    fin_dat = wb_we_o ? '0 : wb_dat_i;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                    fin_tmo = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (finish) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_pop = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address, data and selects keep their last values after the cycle ends
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
        end else begin
            if (start) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= cmd_we_i;
                wb_adr_o <= cmd_adr_i;
                wb_dat_o <= cmd_dat_i;
                wb_sel_o <= cmd_sel_i;
            end
            if (finish) begin
                wb_cyc_o    <= 1'b0;
                wb_stb_o    <= 1'b0;
                wb_we_o     <= 1'b0;
                rsp_valid_o <= 1'b1;
                rsp_dat_o   <= fin_dat;
                rsp_err_o   <= fin_err;
                rsp_tmo_o   <= fin_tmo;
            end
            if (rsp_pop) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule
